// File: rtl/pix_pair_packer.sv
// Packs consecutive RGB666 pixels into 36-bit pairs, tags each pair with its
// bank-1 write address and queues it in a small first-word-fall-through FIFO.
module pix_pair_packer #(
  parameter int H_PIX      = 640,
  parameter int V_LINES    = 480,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        line_start,
  input  logic [17:0] pix_in,
  input  logic        pix_valid,
  output logic [35:0] two_pixel_vals,
  output logic [18:0] write_addr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overflow
);

  localparam int          AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [9:0]  H_LIM    = 10'(H_PIX);
  localparam logic [9:0]  V_LIM    = 10'(V_LINES);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    WAIT_SOF,
    EVEN,
    ODD
  } state_t;

  state_t      state, state_next, base_state;
  logic [9:0]  x, x_next, base_x;
  logic [9:0]  y, y_next, base_y;
  logic        line_pix, line_pix_next, base_line_pix;
  logic [17:0] held_pix;
  logic        accept;
  logic        push;
  logic [35:0] push_word;
  logic [18:0] push_addr;

  logic [35:0]   word_mem [FIFO_DEPTH];
  logic [18:0]   addr_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_next;
  logic [AW:0]   count, count_next, count_after_pop;
  logic          pop, push_ok;

  // Frame/line markers take effect in the cycle they arrive, so a pixel
  // presented alongside them is judged against the realigned position.
  always_comb begin
    base_state    = state;
    base_x        = x;
    base_y        = y;
    base_line_pix = line_pix;
    if (frame_start) begin
      base_state    = EVEN;
      base_x        = '0;
      base_y        = '0;
      base_line_pix = 1'b0;
    end else if (line_start) begin
      base_x        = '0;
      base_line_pix = 1'b0;
      if (line_pix && (y < V_LIM)) begin
        base_y = y + 10'd1;
      end
      if (state != WAIT_SOF) begin
        base_state = EVEN;
      end
    end
    accept = pix_valid && (base_state != WAIT_SOF) && (base_x < H_LIM) && (base_y < V_LIM);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= WAIT_SOF;
      x        <= '0;
      y        <= '0;
      line_pix <= 1'b0;
    end else begin
      state    <= state_next;
      x        <= x_next;
      y        <= y_next;
      line_pix <= line_pix_next;
    end
  end

  always_comb begin
    state_next    = base_state;
    x_next        = base_x;
    y_next        = base_y;
    line_pix_next = base_line_pix;
    if (accept) begin
      x_next        = base_x + 10'd1;
      line_pix_next = 1'b1;
      state_next    = (base_state == EVEN) ? ODD : EVEN;
    end
  end

  // The second pixel of a pair sits at an odd x, so x[9:1] already names the pair.
  always_comb begin
    push      = accept && (base_state == ODD);
    push_word = {held_pix, pix_in};
    push_addr = {base_y, base_x[9:1]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      held_pix <= '0;
    end else if (accept && (base_state == EVEN)) begin
      held_pix <= pix_in;
    end
  end

  always_comb begin
    out_valid   = (count != '0);
    pop         = out_valid && out_ready;
    push_ok     = push && ((count != FULL_CNT) || pop);
    rd_ptr_next = pop ? rd_ptr + 1'b1 : rd_ptr;
    count_after_pop = pop ? count - 1'b1 : count;
    unique case ({push_ok, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      word_mem[wr_ptr] <= push_word;
      addr_mem[wr_ptr] <= push_addr;
    end
  end

  // The head registers are loaded with whatever will be at the front next
  // cycle; a word pushed into an empty (or emptying) FIFO bypasses memory.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      overflow       <= 1'b0;
      two_pixel_vals <= '0;
      write_addr     <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      rd_ptr <= rd_ptr_next;
      count  <= count_next;
      if (push && !push_ok) begin
        overflow <= 1'b1;
      end
      if (count_next != '0) begin
        if (count_after_pop == '0) begin
          two_pixel_vals <= push_word;
          write_addr     <= push_addr;
        end else begin
          two_pixel_vals <= word_mem[rd_ptr_next];
          write_addr     <= addr_mem[rd_ptr_next];
        end
      end
    end
  end

endmodule

// File: tb/tb_pix_pair_packer.sv
// Scoreboard bench for pix_pair_packer: a pixel-position model predicts each
// packed word and its address; a negedge monitor checks words as they leave.
module tb_pix_pair_packer;

  localparam int H     = 40;
  localparam int V     = 12;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_start;
  logic        line_start;
  logic [17:0] pix_in;
  logic        pix_valid;
  logic [35:0] two_pixel_vals;
  logic [18:0] write_addr;
  logic        out_valid;
  logic        out_ready;
  logic        overflow;

  pix_pair_packer #(
    .H_PIX      (H),
    .V_LINES    (V),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .frame_start    (frame_start),
    .line_start     (line_start),
    .pix_in         (pix_in),
    .pix_valid      (pix_valid),
    .two_pixel_vals (two_pixel_vals),
    .write_addr     (write_addr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [35:0] word;
    logic [18:0] addr;
  } exp_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];

  bit          m_active;
  int          m_x, m_y;
  bit          m_line_pix;
  logic [17:0] m_line [0:1023];
  int          m_occ      = 0;
  bit          m_overflow = 1'b0;

  int          words_seen = 0;
  logic [18:0] last_addr  = '0;
  exp_t        mon_e;
  logic [17:0] pix_cnt    = '0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference: pixels are placed on a line by position; an odd position closes a pair
  // with the pixel just before it. The FIFO is only an occupancy count.
  task automatic modelStep();
    bit   pop_m;
    bit   push_m;
    exp_t e;
    if (reset) begin
      m_active   = 1'b0;
      m_x        = 0;
      m_y        = 0;
      m_line_pix = 1'b0;
      m_occ      = 0;
      m_overflow = 1'b0;
      exp_q.delete();
      return;
    end
    pop_m  = (m_occ > 0) && out_ready;
    push_m = 1'b0;
    e      = '0;
    if (frame_start) begin
      m_active   = 1'b1;
      m_x        = 0;
      m_y        = 0;
      m_line_pix = 1'b0;
    end else if (line_start) begin
      if (m_line_pix && m_y < V) m_y++;
      m_x        = 0;
      m_line_pix = 1'b0;
    end
    if (pix_valid && m_active && m_x < H && m_y < V) begin
      m_line[m_x] = pix_in;
      if (m_x % 2 == 1) begin
        e.word = {m_line[m_x-1], pix_in};
        e.addr = 19'(m_y * 512 + m_x / 2);
        push_m = 1'b1;
      end
      m_x++;
      m_line_pix = 1'b1;
    end
    if (push_m) begin
      if (m_occ < DEPTH || pop_m) begin
        exp_q.push_back(e);
        m_occ++;
      end else begin
        m_overflow = 1'b1;
      end
    end
    if (pop_m) m_occ--;
  endtask

  task automatic applyStimulus(input bit fs, input bit ls, input bit pv, input logic [17:0] pix);
    frame_start = fs;
    line_start  = ls;
    pix_valid   = pv;
    pix_in      = pix;
    @(posedge clk);
    modelStep();
    #1;
    frame_start = 1'b0;
    line_start  = 1'b0;
    pix_valid   = 1'b0;
  endtask

  task automatic applyReset();
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 18'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 18'h0);
    reset = 1'b0;
  endtask

  task automatic drainOutput(input int budget);
    int c = 0;
    out_ready = 1'b1;
    while (m_occ > 0 && c < budget) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 18'h0);
      c++;
    end
    if (m_occ > 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL drain_timeout: %0d words still pending, required 0", m_occ);
    end
    checkOutput("queue_empty", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic sendPixels(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 18'($urandom));
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      checkOutput("out_valid", 64'(out_valid), 64'(m_occ > 0));
      checkOutput("overflow", 64'(overflow), 64'(m_overflow));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL unexpected_word: got 0x%0h @0x%0h, required no word", two_pixel_vals, write_addr);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("word", 64'(two_pixel_vals), 64'(mon_e.word));
          checkOutput("addr", 64'(write_addr), 64'(mon_e.addr));
          words_seen++;
          last_addr = write_addr;
        end
      end
    end
  end

  initial begin
    reset       = 1'b1;
    frame_start = 1'b0;
    line_start  = 1'b0;
    pix_valid   = 1'b0;
    pix_in      = '0;
    out_ready   = 1'b0;

    // Basic pair and output latency
    applyReset();
    checkOutput("rst_valid", 64'(out_valid), 64'(0));
    checkOutput("rst_overflow", 64'(overflow), 64'(0));
    checkOutput("rst_word", 64'(two_pixel_vals), 64'(0));
    checkOutput("rst_addr", 64'(write_addr), 64'(0));
    out_ready = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 18'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 18'h00001);
    applyStimulus(1'b0, 1'b0, 1'b1, 18'h00002);
    checkOutput("t1_valid", 64'(out_valid), 64'(1));
    checkOutput("t1_word", 64'(two_pixel_vals), 64'h000040002);
    checkOutput("t1_addr", 64'(write_addr), 64'(0));
    drainOutput(20);

    // Whole frame of running-count pixels with random gaps
    applyReset();
    out_ready  = 1'b1;
    words_seen = 0;
    applyStimulus(1'b1, 1'b0, 1'b0, 18'h0);
    for (int ln = 0; ln < V; ln++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 18'h0);
      for (int px = 0; px < H; px++) begin
        while ($urandom_range(3) == 0) applyStimulus(1'b0, 1'b0, 1'b0, 18'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, pix_cnt);
        pix_cnt = pix_cnt + 18'd1;
      end
    end
    drainOutput(50);
    checkOutput("t2_words", 64'(words_seen), 64'(H * V / 2));
    checkOutput("t2_last_addr", 64'(last_addr), 64'((V - 1) * 512 + H / 2 - 1));
    checkOutput("t2_overflow", 64'(overflow), 64'(0));

    // Stalled consumer: overflow and ordered release
    applyReset();
    out_ready = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 18'h0);
    sendPixels(12);
    applyStimulus(1'b0, 1'b0, 1'b0, 18'h0);
    checkOutput("t3_valid", 64'(out_valid), 64'(1));
    checkOutput("t3_overflow", 64'(overflow), 64'(1));
    words_seen = 0;
    drainOutput(20);
    checkOutput("t3_words", 64'(words_seen), 64'(4));

    // line_start with same-cycle pixel after an odd pixel count
    applyReset();
    out_ready  = 1'b1;
    words_seen = 0;
    applyStimulus(1'b1, 1'b0, 1'b0, 18'h0);
    sendPixels(3);
    applyStimulus(1'b0, 1'b1, 1'b1, 18'($urandom));
    sendPixels(1);
    drainOutput(20);
    checkOutput("t4_words", 64'(words_seen), 64'(2));
    checkOutput("t4_last_addr", 64'(last_addr), 64'(512));

    // Pixels before frame_start, combined markers, pixels past line end
    applyReset();
    out_ready  = 1'b1;
    words_seen = 0;
    sendPixels(4);
    applyStimulus(1'b0, 1'b1, 1'b1, 18'($urandom));
    sendPixels(3);
    checkOutput("t5_pre_sof", 64'(words_seen), 64'(0));
    applyStimulus(1'b1, 1'b1, 1'b1, 18'($urandom));
    sendPixels(1);
    applyStimulus(1'b0, 1'b1, 1'b0, 18'h0);
    sendPixels(H + 2);
    drainOutput(20);
    checkOutput("t5_words", 64'(words_seen), 64'(1 + H / 2));
    checkOutput("t5_last_addr", 64'(last_addr), 64'(512 + H / 2 - 1));

    // Push into a full FIFO with a same-cycle pop, then reset mid-line
    applyReset();
    out_ready = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 18'h0);
    sendPixels(9);
    out_ready = 1'b1;
    sendPixels(7);
    checkOutput("t6_overflow", 64'(overflow), 64'(0));
    drainOutput(20);
    out_ready = 1'b0;
    sendPixels(3);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 18'($urandom));
    reset = 1'b0;
    checkOutput("t6_rst_valid", 64'(out_valid), 64'(0));
    out_ready = 1'b1;
    sendPixels(4);
    applyStimulus(1'b0, 1'b0, 1'b0, 18'h0);
    checkOutput("t6_wait_sof", 64'(out_valid), 64'(0));

    // Random mix of markers, gaps and backpressure
    applyReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 18'h0);
    for (int i = 0; i < 800; i++) begin
      out_ready = ($urandom_range(3) != 0);
      applyStimulus($urandom_range(299) == 0, $urandom_range(29) == 0,
                    $urandom_range(3) != 0, 18'($urandom));
    end
    drainOutput(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
